// File: rtl/atomrvcore_pkg.sv
// Shared atomRVCORE definitions: load funct3 encodings and their legality check.
package atomrvcore_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Encodings that are not a defined load width.
  function automatic logic f3_illegal(input logic [2:0] f3);
    return (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/atomrvcore_load_align.sv
// Combinational load aligner: picks the addressed byte/half from a word-aligned
// read, sign/zero-extends it, and flags misaligned or undefined loads.
module atomrvcore_load_align
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic [DATAWIDTH-1:0] dt,
  input  logic [2:0]           funct3,
  input  logic [1:0]           offset,
  output logic [DATAWIDTH-1:0] data,
  output logic                 err
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign ld_byte = dt[{offset, 3'b000} +: 8];
  assign ld_half = dt[{offset[1], 4'b0000} +: 16];

  // Width selection and extension; LW and undefined encodings pass the word.
  always_comb begin
    data = dt;
    case (funct3)
      LB:      data = {{(DATAWIDTH-8){ld_byte[7]}}, ld_byte};
      LBU:     data = {{(DATAWIDTH-8){1'b0}}, ld_byte};
      LH:      data = {{(DATAWIDTH-16){ld_half[15]}}, ld_half};
      LHU:     data = {{(DATAWIDTH-16){1'b0}}, ld_half};
      default: data = dt;
    endcase
  end

  // Half loads need an even offset, word loads need offset zero.
  always_comb begin
    err = f3_illegal(funct3)
        | (((funct3 == LH) || (funct3 == LHU)) & offset[0])
        | ((funct3 == LW) & (offset != 2'b00));
  end

endmodule

// File: rtl/atomrvcore_writeback.sv
// atomRVCORE writeback stage: aligns loads from the DCCM stage, selects the
// result, forwards it combinationally and registers the register-file write.
module atomrvcore_writeback
  import atomrvcore_pkg::*;
#(
  parameter int unsigned DATAWIDTH        = 32,
  parameter int unsigned REG_ADRESS_WIDTH = 5,
  parameter int unsigned CNTWIDTH         = 64
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        valid_i,
  input  logic                        flush_i,
  input  logic                        is_load_i,
  input  logic [2:0]                  ld_funct3_i,
  input  logic [1:0]                  ld_offset_i,
  input  logic                        dccm_rwr_en_i,
  input  logic [REG_ADRESS_WIDTH-1:0] dccm_rd_i,
  input  logic [DATAWIDTH-1:0]        dccm_wr_i,
  input  logic [DATAWIDTH-1:0]        dccm_dt_i,
  output logic                        fwd_valid_o,
  output logic [REG_ADRESS_WIDTH-1:0] fwd_rd_o,
  output logic [DATAWIDTH-1:0]        fwd_data_o,
  output logic                        rf_we_o,
  output logic [REG_ADRESS_WIDTH-1:0] rf_waddr_o,
  output logic [DATAWIDTH-1:0]        rf_wdata_o,
  output logic                        ld_err_o,
  output logic [CNTWIDTH-1:0]         instret_o
);

  logic                 v1;
  logic                 ld1;
  logic [2:0]           f3_1;
  logic [1:0]           off1;
  logic [DATAWIDTH-1:0] ld_data;
  logic                 ld_bad;
  logic                 err;
  logic                 we;
  logic [DATAWIDTH-1:0] wd;

  // Sideband capture so load type/offset line up with the DCCM stage outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v1   <= 1'b0;
      ld1  <= 1'b0;
      f3_1 <= '0;
      off1 <= '0;
    end else begin
      v1   <= valid_i & ~flush_i;
      ld1  <= is_load_i;
      f3_1 <= ld_funct3_i;
      off1 <= ld_offset_i;
    end
  end

  atomrvcore_load_align #(
    .DATAWIDTH (DATAWIDTH)
  ) u_load_align (
    .dt     (dccm_dt_i),
    .funct3 (f3_1),
    .offset (off1),
    .data   (ld_data),
    .err    (ld_bad)
  );

  // Result select and write qualification for the instruction now in S+1.
  always_comb begin
    err = v1 & ld1 & ld_bad;
    wd  = ld1 ? ld_data : dccm_wr_i;
    we  = v1 & dccm_rwr_en_i & (dccm_rd_i != '0) & ~err;
  end

  assign fwd_valid_o = we;
  assign fwd_rd_o    = dccm_rd_i;
  assign fwd_data_o  = wd;

  // Register-file write port and error pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rf_we_o    <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
      ld_err_o   <= 1'b0;
    end else begin
      rf_we_o    <= we;
      rf_waddr_o <= dccm_rd_i;
      rf_wdata_o <= wd;
      ld_err_o   <= err;
    end
  end

  // Retired-instruction counter: every valid, non-errored instruction counts.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      instret_o <= '0;
    end else if (v1 & ~err) begin
      instret_o <= instret_o + CNTWIDTH'(1);
    end
  end

endmodule

// File: tb/tb_atomrvcore_writeback.sv
// Randomized and directed bench for atomrvcore_writeback against a
// transaction-level reference model.
module tb_atomrvcore_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, flush, is_load;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        rwr_en;
  logic [4:0]  rd;
  logic [31:0] wr, dt;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ld_err;
  logic [63:0] instret;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  always #5 clk = ~clk;

  atomrvcore_writeback #(
    .DATAWIDTH        (32),
    .REG_ADRESS_WIDTH (5),
    .CNTWIDTH         (64)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid),
    .flush_i       (flush),
    .is_load_i     (is_load),
    .ld_funct3_i   (f3),
    .ld_offset_i   (off),
    .dccm_rwr_en_i (rwr_en),
    .dccm_rd_i     (rd),
    .dccm_wr_i     (wr),
    .dccm_dt_i     (dt),
    .fwd_valid_o   (fwd_valid),
    .fwd_rd_o      (fwd_rd),
    .fwd_data_o    (fwd_data),
    .rf_we_o       (rf_we),
    .rf_waddr_o    (rf_waddr),
    .rf_wdata_o    (rf_wdata),
    .ld_err_o      (ld_err),
    .instret_o     (instret)
  );

  typedef struct {
    logic        valid, flush, is_load;
    logic [2:0]  f3;
    logic [1:0]  off;
    logic        rwr_en;
    logic [4:0]  rd;
    logic [31:0] wr, dt;
  } txn_t;

  txn_t        pend;
  txn_t        empty_t;
  logic [63:0] m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic undefined_f3(input logic [2:0] f);
    return (f == 3) || (f == 6) || (f == 7);
  endfunction

  function automatic logic model_bad(input txn_t t);
    if (undefined_f3(t.f3)) return 1'b1;
    if ((t.f3 == 1 || t.f3 == 5) && (t.off % 2 != 0)) return 1'b1;
    if (t.f3 == 2 && t.off != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] model_load(input txn_t t);
    int unsigned b, h;
    b = (t.dt >> (8 * t.off)) & 32'hFF;
    h = (t.dt >> (16 * (t.off / 2))) & 32'hFFFF;
    case (t.f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      4: return b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      5: return h;
      default: return t.dt;
    endcase
  endfunction

  // One cycle: present t at execute and the previous transaction at DCCM,
  // check forwarding before the edge and the write port after it.
  task automatic step(input txn_t t);
    logic        live, e_err, e_we;
    logic [31:0] e_wd;
    valid   = t.valid;   flush = t.flush;  is_load = t.is_load;
    f3      = t.f3;      off   = t.off;
    rwr_en  = pend.rwr_en; rd = pend.rd;   wr = pend.wr; dt = pend.dt;
    live  = pend.valid & ~pend.flush;
    e_err = live & pend.is_load & model_bad(pend);
    e_we  = live & pend.rwr_en & (pend.rd != 0) & ~e_err;
    e_wd  = pend.is_load ? model_load(pend) : pend.wr;
    #1;
    chk("fwd_valid", {63'd0, fwd_valid}, {63'd0, e_we});
    if (e_we) begin
      chk("fwd_rd", {59'd0, fwd_rd}, {59'd0, pend.rd});
      chk("fwd_data", {32'd0, fwd_data}, {32'd0, e_wd});
    end
    @(posedge clk); #1;
    if (live & ~e_err) m_cnt = m_cnt + 1;
    chk("rf_we", {63'd0, rf_we}, {63'd0, e_we});
    chk("ld_err", {63'd0, ld_err}, {63'd0, e_err});
    chk("rf_waddr", {59'd0, rf_waddr}, {59'd0, pend.rd});
    if (!(pend.is_load && undefined_f3(pend.f3)))
      chk("rf_wdata", {32'd0, rf_wdata}, {32'd0, e_wd});
    chk("instret", instret, m_cnt);
    pend = t;
    @(negedge clk);
  endtask

  function automatic txn_t mk(input logic v, input logic fl, input logic ld,
                              input logic [2:0] f, input logic [1:0] o,
                              input logic we, input logic [4:0] r,
                              input logic [31:0] w, input logic [31:0] d);
    txn_t t;
    t.valid = v; t.flush = fl; t.is_load = ld; t.f3 = f; t.off = o;
    t.rwr_en = we; t.rd = r; t.wr = w; t.dt = d;
    return t;
  endfunction

  function automatic txn_t rnd();
    txn_t t;
    t.valid   = ($urandom_range(0, 9) < 8);
    t.flush   = ($urandom_range(0, 9) == 0);
    t.is_load = $urandom_range(0, 1);
    t.f3      = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7))
                                            : 3'($urandom_range(0, 2));
    if ($urandom_range(0, 1) == 1 && t.f3 != 2) t.f3 = t.f3 | 3'b100;
    t.off     = 2'($urandom_range(0, 3));
    t.rwr_en  = ($urandom_range(0, 4) != 0);
    t.rd      = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    t.wr      = $urandom;
    t.dt      = $urandom;
    return t;
  endfunction

  txn_t t;
  txn_t idle;
  logic [31:0] ld_exp [5];
  logic [2:0]  ld_f3  [5];
  logic [1:0]  ld_off [5];

  initial begin
    empty_t = mk(0, 0, 0, 3'd0, 2'd0, 0, 5'd0, 32'd0, 32'd0);
    idle    = empty_t;
    pend    = empty_t;
    m_cnt   = 0;
    rst_n = 1'b0; valid = 1'b1; flush = 1'b0; is_load = 1'b0;
    f3 = '0; off = '0; rwr_en = 1'b1; rd = 5'd7; wr = 32'hDEAD_BEEF; dt = '0;
    repeat (2) @(negedge clk);
    chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("rst_instret", instret, 64'd0);
    chk("rst_ld_err", {63'd0, ld_err}, 64'd0);
    rst_n = 1'b1;

    // ALU op rd=5
    step(mk(1, 0, 0, 3'd0, 2'd0, 1, 5'd5, 32'h0000_1234, 32'd0));
    step(idle);
    chk("alu_wdata", {32'd0, rf_wdata}, 64'h1234);
    chk("alu_instret", instret, 64'd1);

    // Sub-word loads from 0x80FF_7F01
    ld_f3[0] = 3'b000; ld_off[0] = 2'd1; ld_exp[0] = 32'h0000_007F;
    ld_f3[1] = 3'b000; ld_off[1] = 2'd3; ld_exp[1] = 32'hFFFF_FF80;
    ld_f3[2] = 3'b100; ld_off[2] = 2'd2; ld_exp[2] = 32'h0000_00FF;
    ld_f3[3] = 3'b001; ld_off[3] = 2'd2; ld_exp[3] = 32'hFFFF_80FF;
    ld_f3[4] = 3'b101; ld_off[4] = 2'd0; ld_exp[4] = 32'h0000_7F01;
    for (int i = 0; i < 5; i++) begin
      step(mk(1, 0, 1, ld_f3[i], ld_off[i], 1, 5'd9, 32'd0, 32'h80FF_7F01));
      step(idle);
      chk($sformatf("load%0d", i), {32'd0, rf_wdata}, {32'd0, ld_exp[i]});
    end

    // Misaligned / undefined loads
    step(mk(1, 0, 1, 3'b010, 2'd2, 1, 5'd3, 32'd0, 32'h1111_2222));
    step(mk(1, 0, 1, 3'b001, 2'd1, 1, 5'd3, 32'd0, 32'h1111_2222));
    step(mk(1, 0, 1, 3'b011, 2'd0, 1, 5'd3, 32'd0, 32'h1111_2222));
    step(idle);

    // x0 write and flushed instruction
    step(mk(1, 0, 0, 3'd0, 2'd0, 1, 5'd0, 32'h5555_5555, 32'd0));
    step(mk(1, 1, 0, 3'd0, 2'd0, 1, 5'd6, 32'h6666_6666, 32'd0));
    step(idle);

    // Back-to-back writes to rd 1..4
    for (int i = 1; i <= 4; i++)
      step(mk(1, 0, 0, 3'd0, 2'd0, 1, 5'(i), 32'(i * 32'h101), 32'd0));
    step(idle);

    // Reset mid-stream with a valid instruction in flight
    step(mk(1, 0, 0, 3'd0, 2'd0, 1, 5'd8, 32'hAAAA_0000, 32'd0));
    valid = 1'b1; rwr_en = 1'b1; rd = 5'd8;
    rst_n = 1'b0;
    #1;
    chk("midrst_rf_we", {63'd0, rf_we}, 64'd0);
    chk("midrst_instret", instret, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    pend  = empty_t;
    m_cnt = 0;
    step(mk(1, 0, 0, 3'd0, 2'd0, 1, 5'd12, 32'h0BAD_F00D, 32'd0));
    step(idle);
    chk("post_rst_wdata", {32'd0, rf_wdata}, 64'h0BAD_F00D);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      t = rnd();
      step(t);
    end
    step(idle);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
